mem_stage_hs: RTL and testbench

- Parametrised successor MEM stage for the RV pipeline; sits between EX/MEM and WB pipeline registers.
- Generalised to XLEN 32/64 and to a req/gnt/rvalid data bus with variable latency, replacing a fixed single-cycle memory.
- Adds pipeline stall generation, flush, misalignment and bus-error exceptions, and a registered WB output with a valid bit.

---
 rtl/mem_stage_hs_if.sv | 31 +++
 rtl/mem_stage_hs.sv | 214 +++++++++++++++++++++
 tb/tb_mem_stage_hs.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_hs_if.sv
// Data-bus bundle between the MEM stage (master) and the memory system (slave).
// Handshake: a request is held stable while dbus_req=1 and dbus_gnt=0, and it is
// accepted in the cycle dbus_req=1 and dbus_gnt=1. Each accepted request later gets
// exactly one dbus_rvalid pulse. dbus_rdata and dbus_err are meaningful only in that
// cycle.
interface mem_stage_hs_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  localparam int STRB_W = XLEN / 8;

  logic              dbus_req;
  logic              dbus_we;
  logic [ADDR_W-1:0] dbus_addr;
  logic [XLEN-1:0]   dbus_wdata;
  logic [STRB_W-1:0] dbus_strb;
  logic              dbus_gnt;
  logic              dbus_rvalid;
  logic [XLEN-1:0]   dbus_rdata;
  logic              dbus_err;

  modport master (
    output dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_strb,
    input  dbus_gnt, dbus_rvalid, dbus_rdata, dbus_err
  );

  modport slave (
    input  dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_strb,
    output dbus_gnt, dbus_rvalid, dbus_rdata, dbus_err
  );
endinterface

// File: rtl/mem_stage_hs.sv
// MEM pipeline stage with a variable-latency req/gnt/rvalid data bus.
// It issues loads and stores, stalls upstream while a bus access is in flight,
// detects misalignment and bus faults, and registers the WB slot.
// fsm_state exposes the bus FSM (0 IDLE, 1 REQ, 2 WAIT) for debug.
module mem_stage_hs #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [XLEN-1:0]   in_alu_result,
  input  logic [XLEN-1:0]   in_store_data,
  input  logic [XLEN-1:0]   in_link_addr,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic [2:0]        in_mem_type,
  input  logic [4:0]        in_rd,
  input  logic              in_reg_write,
  input  logic [1:0]        in_wb_sel,
  input  logic              flush,
  mem_stage_hs_if.master    dbus,
  output logic              stall,
  output logic              wb_valid,
  output logic [XLEN-1:0]   wb_data,
  output logic [4:0]        wb_rd,
  output logic              wb_reg_write,
  output logic              exc_valid,
  output logic [3:0]        exc_cause,
  output logic [XLEN-1:0]   exc_addr,
  output logic [1:0]        fsm_state
);
  localparam int STRB_W = XLEN / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} state_t;
  state_t state, state_nx;

  // Decode of the instruction currently presented by EX/MEM.
  logic [OFF_W-1:0]  in_off;
  logic [OFF_W-1:0]  align_mask;
  logic [STRB_W-1:0] strb_base;
  logic              type_legal, misaligned, in_is_mem, issue;
  logic [XLEN-1:0]   in_wdata_sh;
  logic [STRB_W-1:0] in_strb_sh;
  logic [ADDR_W-1:0] in_addr;

  // Captured request, kept stable for REQ and used to format the response.
  logic              q_we, q_reg_write, q_killed;
  logic [ADDR_W-1:0] q_addr;
  logic [XLEN-1:0]   q_wdata, q_alu, q_link;
  logic [STRB_W-1:0] q_strb;
  logic [2:0]        q_type;
  logic [OFF_W-1:0]  q_off;
  logic [4:0]        q_rd;
  logic [1:0]        q_wb_sel;
  logic [XLEN-1:0]   rd_shift, load_data;

  assign in_off    = in_alu_result[OFF_W-1:0];
  assign in_is_mem = in_mem_read | in_mem_write;

  // Access size as an alignment mask and a base byte-enable; D/WU only exist on XLEN=64.
  always_comb begin
    align_mask = '0;
    strb_base  = STRB_W'(1);
    case (in_mem_type[1:0])
      2'b01:   begin align_mask = OFF_W'(1); strb_base = STRB_W'(4'h3);  end
      2'b10:   begin align_mask = OFF_W'(3); strb_base = STRB_W'(4'hF);  end
      2'b11:   begin align_mask = OFF_W'(7); strb_base = STRB_W'(8'hFF); end
      default: begin align_mask = '0;        strb_base = STRB_W'(1);     end
    endcase
    case (in_mem_type)
      3'b011, 3'b110: type_legal = (XLEN == 64);
      3'b111:         type_legal = 1'b0;
      default:        type_legal = 1'b1;
    endcase
  end

  assign misaligned  = !type_legal || ((in_off & align_mask) != '0);
  assign in_wdata_sh = in_store_data << {in_off, 3'b000};
  assign in_strb_sh  = strb_base << in_off;
  assign in_addr     = in_alu_result[ADDR_W-1:0] & ~ADDR_W'(STRB_W - 1);
  // Reset gates the request so every output reads 0 while rst is high.
  assign issue = (state == S_IDLE) && !rst && in_valid && in_is_mem && !misaligned && !flush;

  // Select the addressed bytes from the read beat and extend them to XLEN.
  always_comb begin
    rd_shift = dbus.dbus_rdata >> {q_off, 3'b000};
    case (q_type)
      3'b000:  load_data = XLEN'(signed'(rd_shift[7:0]));
      3'b001:  load_data = XLEN'(signed'(rd_shift[15:0]));
      3'b010:  load_data = XLEN'(signed'(rd_shift[31:0]));
      3'b100:  load_data = XLEN'(rd_shift[7:0]);
      3'b101:  load_data = XLEN'(rd_shift[15:0]);
      3'b110:  load_data = XLEN'(rd_shift[31:0]);
      default: load_data = rd_shift;
    endcase
  end

  function automatic logic [XLEN-1:0] wb_mux(input logic [1:0] sel, input logic [XLEN-1:0] alu,
                                             input logic [XLEN-1:0] ld, input logic [XLEN-1:0] link);
    case (sel)
      2'b00:   return alu;
      2'b01:   return ld;
      2'b10:   return link;
      default: return '0;
    endcase
  endfunction

  // Bus FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next state, bus outputs and stall; a raised request is never retracted.
  always_comb begin
    state_nx        = state;
    stall           = 1'b0;
    dbus.dbus_req   = 1'b0;
    dbus.dbus_we    = 1'b0;
    dbus.dbus_addr  = '0;
    dbus.dbus_wdata = '0;
    dbus.dbus_strb  = '0;
    case (state)
      S_IDLE: begin
        if (issue) begin
          dbus.dbus_req   = 1'b1;
          dbus.dbus_we    = in_mem_write;
          dbus.dbus_addr  = in_addr;
          dbus.dbus_wdata = in_mem_write ? in_wdata_sh : '0;
          dbus.dbus_strb  = in_mem_write ? in_strb_sh : '0;
          stall           = 1'b1;
          state_nx        = dbus.dbus_gnt ? S_WAIT : S_REQ;
        end
      end
      S_REQ: begin
        dbus.dbus_req   = 1'b1;
        dbus.dbus_we    = q_we;
        dbus.dbus_addr  = q_addr;
        dbus.dbus_wdata = q_wdata;
        dbus.dbus_strb  = q_strb;
        stall           = 1'b1;
        if (dbus.dbus_gnt) state_nx = S_WAIT;
      end
      S_WAIT: begin
        stall = !dbus.dbus_rvalid;
        if (dbus.dbus_rvalid) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Capture the request on issue; a flush while in flight marks the result killed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_we <= 1'b0; q_reg_write <= 1'b0; q_killed <= 1'b0;
      q_addr <= '0; q_wdata <= '0; q_alu <= '0; q_link <= '0; q_strb <= '0;
      q_type <= '0; q_off <= '0; q_rd <= '0; q_wb_sel <= '0;
    end else if (issue) begin
      q_we        <= in_mem_write;
      q_reg_write <= in_reg_write;
      q_killed    <= 1'b0;
      q_addr      <= in_addr;
      q_wdata     <= in_mem_write ? in_wdata_sh : '0;
      q_strb      <= in_mem_write ? in_strb_sh : '0;
      q_alu       <= in_alu_result;
      q_link      <= in_link_addr;
      q_type      <= in_mem_type;
      q_off       <= in_off;
      q_rd        <= in_rd;
      q_wb_sel    <= in_wb_sel;
    end else if (state != S_IDLE && flush) begin
      q_killed <= 1'b1;
    end
  end

  // Registered WB slot and exception pulse; the two never fire together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid <= 1'b0; wb_data <= '0; wb_rd <= '0; wb_reg_write <= 1'b0;
      exc_valid <= 1'b0; exc_cause <= '0; exc_addr <= '0;
    end else begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      exc_valid    <= 1'b0;
      if (state == S_IDLE && in_valid && !flush) begin
        if (in_is_mem && misaligned) begin
          exc_valid <= 1'b1;
          exc_cause <= in_mem_write ? 4'd6 : 4'd4;
          exc_addr  <= in_alu_result;
        end else if (!in_is_mem) begin
          wb_valid     <= 1'b1;
          wb_data      <= wb_mux(in_wb_sel, in_alu_result, '0, in_link_addr);
          wb_rd        <= in_rd;
          wb_reg_write <= in_reg_write;
        end
      end else if (state == S_WAIT && dbus.dbus_rvalid && !(q_killed || flush)) begin
        if (dbus.dbus_err) begin
          exc_valid <= 1'b1;
          exc_cause <= q_we ? 4'd7 : 4'd5;
          exc_addr  <= q_alu;
        end else begin
          wb_valid     <= 1'b1;
          wb_data      <= wb_mux(q_wb_sel, q_alu, load_data, q_link);
          wb_rd        <= q_rd;
          wb_reg_write <= q_reg_write;
        end
      end
    end
  end

  assign fsm_state = state;
endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs: one XLEN=32 and one XLEN=64 instance.
module tb_mem_stage_hs;
  logic        clk, rst;
  logic        in_valid32, in_valid64;
  logic [63:0] alu, sdata, link;
  logic        mem_read, mem_write, reg_write, flush;
  logic [2:0]  mem_type;
  logic [4:0]  rd;
  logic [1:0]  wb_sel;

  logic        stall32, wb_valid32, wb_reg_write32, exc_valid32;
  logic [31:0] wb_data32, exc_addr32;
  logic [4:0]  wb_rd32;
  logic [3:0]  exc_cause32;
  logic [1:0]  fsm32;
  logic        stall64, wb_valid64, wb_reg_write64, exc_valid64;
  logic [63:0] wb_data64, exc_addr64;
  logic [4:0]  wb_rd64;
  logic [3:0]  exc_cause64;
  logic [1:0]  fsm64;

  int checks = 0;
  int errors = 0;

  mem_stage_hs_if #(.XLEN(32), .ADDR_W(32)) bus32 ();
  mem_stage_hs_if #(.XLEN(64), .ADDR_W(32)) bus64 ();

  mem_stage_hs #(.XLEN(32), .ADDR_W(32)) u32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_alu_result(alu[31:0]),
    .in_store_data(sdata[31:0]), .in_link_addr(link[31:0]), .in_mem_read(mem_read),
    .in_mem_write(mem_write), .in_mem_type(mem_type), .in_rd(rd), .in_reg_write(reg_write),
    .in_wb_sel(wb_sel), .flush(flush), .dbus(bus32.master), .stall(stall32),
    .wb_valid(wb_valid32), .wb_data(wb_data32), .wb_rd(wb_rd32), .wb_reg_write(wb_reg_write32),
    .exc_valid(exc_valid32), .exc_cause(exc_cause32), .exc_addr(exc_addr32), .fsm_state(fsm32)
  );

  mem_stage_hs #(.XLEN(64), .ADDR_W(32)) u64 (
    .clk(clk), .rst(rst), .in_valid(in_valid64), .in_alu_result(alu),
    .in_store_data(sdata), .in_link_addr(link), .in_mem_read(mem_read),
    .in_mem_write(mem_write), .in_mem_type(mem_type), .in_rd(rd), .in_reg_write(reg_write),
    .in_wb_sel(wb_sel), .flush(flush), .dbus(bus64.master), .stall(stall64),
    .wb_valid(wb_valid64), .wb_data(wb_data64), .wb_rd(wb_rd64), .wb_reg_write(wb_reg_write64),
    .exc_valid(exc_valid64), .exc_cause(exc_cause64), .exc_addr(exc_addr64), .fsm_state(fsm64)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks
  task automatic clear_inputs();
    in_valid32 = 0; in_valid64 = 0; alu = '0; sdata = '0; link = '0;
    mem_read = 0; mem_write = 0; mem_type = 3'b000; rd = '0; reg_write = 0;
    wb_sel = 2'b00; flush = 0;
    bus32.dbus_gnt = 0; bus32.dbus_rvalid = 0; bus32.dbus_rdata = '0; bus32.dbus_err = 0;
    bus64.dbus_gnt = 0; bus64.dbus_rvalid = 0; bus64.dbus_rdata = '0; bus64.dbus_err = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (stall32 !== 1'b0) begin errors++; $display("FAIL rst_stall: got %h exp 0", stall32); end
    checks++; if (bus32.dbus_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %h exp 0", bus32.dbus_req); end
    checks++; if (wb_valid32 !== 1'b0) begin errors++; $display("FAIL rst_wb_valid: got %h exp 0", wb_valid32); end
    checks++; if (wb_data32 !== 32'h0) begin errors++; $display("FAIL rst_wb_data: got %h exp 0", wb_data32); end
    checks++; if (exc_valid32 !== 1'b0) begin errors++; $display("FAIL rst_exc_valid: got %h exp 0", exc_valid32); end
    checks++; if (fsm32 !== 2'd0) begin errors++; $display("FAIL rst_fsm: got %h exp 0", fsm32); end
    checks++; if (wb_valid64 !== 1'b0) begin errors++; $display("FAIL rst_wb_valid64: got %h exp 0", wb_valid64); end
  endtask

  task automatic test_load_byte();
    in_valid32 = 1; mem_read = 1; mem_type = 3'b000; alu = 64'h1003; rd = 5'd5;
    reg_write = 1; wb_sel = 2'b01; bus32.dbus_gnt = 1;
    #1;
    checks++; if (bus32.dbus_req !== 1'b1) begin errors++; $display("FAIL lb_req: got %h exp 1", bus32.dbus_req); end
    checks++; if (bus32.dbus_addr !== 32'h1000) begin errors++; $display("FAIL lb_addr: got %h exp 1000", bus32.dbus_addr); end
    checks++; if (bus32.dbus_strb !== 4'b0000) begin errors++; $display("FAIL lb_strb: got %b exp 0000", bus32.dbus_strb); end
    checks++; if (bus32.dbus_we !== 1'b0) begin errors++; $display("FAIL lb_we: got %h exp 0", bus32.dbus_we); end
    checks++; if (stall32 !== 1'b1) begin errors++; $display("FAIL lb_stall_issue: got %h exp 1", stall32); end
    tick();
    bus32.dbus_gnt = 0; bus32.dbus_rvalid = 1; bus32.dbus_rdata = 32'h80FF_FF00;
    #1;
    checks++; if (fsm32 !== 2'd2) begin errors++; $display("FAIL lb_fsm_wait: got %h exp 2", fsm32); end
    checks++; if (stall32 !== 1'b0) begin errors++; $display("FAIL lb_stall_rvalid: got %h exp 0", stall32); end
    checks++; if (wb_valid32 !== 1'b0) begin errors++; $display("FAIL lb_wb_early: got %h exp 0", wb_valid32); end
    tick();
    clear_inputs();
    checks++; if (wb_valid32 !== 1'b1) begin errors++; $display("FAIL lb_wb_valid: got %h exp 1", wb_valid32); end
    checks++; if (wb_data32 !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_wb_data: got %h exp ffffff80", wb_data32); end
    checks++; if (wb_rd32 !== 5'd5) begin errors++; $display("FAIL lb_wb_rd: got %h exp 5", wb_rd32); end
    checks++; if (wb_reg_write32 !== 1'b1) begin errors++; $display("FAIL lb_wb_rw: got %h exp 1", wb_reg_write32); end
    checks++; if (fsm32 !== 2'd0) begin errors++; $display("FAIL lb_fsm_idle: got %h exp 0", fsm32); end
    tick();
    checks++; if (wb_valid32 !== 1'b0) begin errors++; $display("FAIL lb_wb_pulse: got %h exp 0", wb_valid32); end
  endtask

  task automatic test_store_half();
    in_valid32 = 1; mem_write = 1; mem_type = 3'b001; alu = 64'h2002; sdata = 64'hABCD;
    rd = 5'd0; reg_write = 0; wb_sel = 2'b00; bus32.dbus_gnt = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus32.dbus_req !== 1'b1 || bus32.dbus_addr !== 32'h2000)
        begin errors++; $display("FAIL sh_req_hold[%0d]: got req %h addr %h exp 1 2000", i, bus32.dbus_req, bus32.dbus_addr); end
      checks++; if (bus32.dbus_wdata !== 32'hABCD_0000 || bus32.dbus_strb !== 4'b1100 || bus32.dbus_we !== 1'b1)
        begin errors++; $display("FAIL sh_lanes[%0d]: got wdata %h strb %b we %h exp abcd0000 1100 1", i, bus32.dbus_wdata, bus32.dbus_strb, bus32.dbus_we); end
      checks++; if (stall32 !== 1'b1) begin errors++; $display("FAIL sh_stall[%0d]: got %h exp 1", i, stall32); end
      tick();
    end
    bus32.dbus_gnt = 1;
    #1;
    checks++; if (fsm32 !== 2'd1 || stall32 !== 1'b1 || bus32.dbus_req !== 1'b1)
      begin errors++; $display("FAIL sh_gnt: got fsm %h stall %h req %h exp 1 1 1", fsm32, stall32, bus32.dbus_req); end
    tick();
    bus32.dbus_gnt = 0;
    #1;
    checks++; if (fsm32 !== 2'd2 || stall32 !== 1'b1 || bus32.dbus_req !== 1'b0)
      begin errors++; $display("FAIL sh_wait: got fsm %h stall %h req %h exp 2 1 0", fsm32, stall32, bus32.dbus_req); end
    tick();
    bus32.dbus_rvalid = 1;
    #1;
    checks++; if (stall32 !== 1'b0) begin errors++; $display("FAIL sh_stall_release: got %h exp 0", stall32); end
    tick();
    clear_inputs();
    checks++; if (wb_valid32 !== 1'b1) begin errors++; $display("FAIL sh_wb_valid: got %h exp 1", wb_valid32); end
    checks++; if (wb_reg_write32 !== 1'b0) begin errors++; $display("FAIL sh_wb_rw: got %h exp 0", wb_reg_write32); end
    checks++; if (wb_data32 !== 32'h2002) begin errors++; $display("FAIL sh_wb_data: got %h exp 2002", wb_data32); end
  endtask

  task automatic test_misaligned();
    // LW at 0x3001
    in_valid32 = 1; mem_read = 1; mem_type = 3'b010; alu = 64'h3001; rd = 5'd3; reg_write = 1; wb_sel = 2'b01;
    #1;
    checks++; if (bus32.dbus_req !== 1'b0 || stall32 !== 1'b0)
      begin errors++; $display("FAIL lw_mis_bus: got req %h stall %h exp 0 0", bus32.dbus_req, stall32); end
    tick();
    clear_inputs();
    checks++; if (exc_valid32 !== 1'b1 || exc_cause32 !== 4'd4 || exc_addr32 !== 32'h3001)
      begin errors++; $display("FAIL lw_mis_exc: got %h %h %h exp 1 4 3001", exc_valid32, exc_cause32, exc_addr32); end
    checks++; if (wb_valid32 !== 1'b0 || wb_reg_write32 !== 1'b0)
      begin errors++; $display("FAIL lw_mis_wb: got %h %h exp 0 0", wb_valid32, wb_reg_write32); end
    // SW at 0x3002
    in_valid32 = 1; mem_write = 1; mem_type = 3'b010; alu = 64'h3002; sdata = 64'h1234;
    #1;
    checks++; if (bus32.dbus_req !== 1'b0) begin errors++; $display("FAIL sw_mis_req: got %h exp 0", bus32.dbus_req); end
    tick();
    clear_inputs();
    checks++; if (exc_valid32 !== 1'b1 || exc_cause32 !== 4'd6 || exc_addr32 !== 32'h3002)
      begin errors++; $display("FAIL sw_mis_exc: got %h %h %h exp 1 6 3002", exc_valid32, exc_cause32, exc_addr32); end
    // LD is not a legal type at XLEN=32, even when aligned
    in_valid32 = 1; mem_read = 1; mem_type = 3'b011; alu = 64'h3000;
    #1;
    checks++; if (bus32.dbus_req !== 1'b0) begin errors++; $display("FAIL ld32_req: got %h exp 0", bus32.dbus_req); end
    tick();
    clear_inputs();
    checks++; if (exc_valid32 !== 1'b1 || exc_cause32 !== 4'd4 || exc_addr32 !== 32'h3000)
      begin errors++; $display("FAIL ld32_exc: got %h %h %h exp 1 4 3000", exc_valid32, exc_cause32, exc_addr32); end
    tick();
    checks++; if (exc_valid32 !== 1'b0) begin errors++; $display("FAIL mis_exc_pulse: got %h exp 0", exc_valid32); end
  endtask

  task automatic test_lwu_64();
    in_valid64 = 1; mem_read = 1; mem_type = 3'b110; alu = 64'h4004; rd = 5'd9; reg_write = 1;
    wb_sel = 2'b01; bus64.dbus_gnt = 1;
    #1;
    checks++; if (bus64.dbus_req !== 1'b1 || bus64.dbus_addr !== 32'h4000 || bus64.dbus_strb !== 8'h00)
      begin errors++; $display("FAIL lwu64_bus: got %h %h %h exp 1 4000 00", bus64.dbus_req, bus64.dbus_addr, bus64.dbus_strb); end
    tick();
    bus64.dbus_gnt = 0; bus64.dbus_rvalid = 1; bus64.dbus_rdata = 64'hF000_0001_0000_0000;
    tick();
    clear_inputs();
    checks++; if (wb_valid64 !== 1'b1 || wb_data64 !== 64'h0000_0000_F000_0001)
      begin errors++; $display("FAIL lwu64_data: got %h %h exp 1 00000000f0000001", wb_valid64, wb_data64); end
    // Same beat through LW sign-extends
    in_valid64 = 1; mem_read = 1; mem_type = 3'b010; alu = 64'h4004; rd = 5'd9; reg_write = 1;
    wb_sel = 2'b01; bus64.dbus_gnt = 1;
    tick();
    bus64.dbus_gnt = 0; bus64.dbus_rvalid = 1; bus64.dbus_rdata = 64'hF000_0001_0000_0000;
    tick();
    clear_inputs();
    checks++; if (wb_valid64 !== 1'b1 || wb_data64 !== 64'hFFFF_FFFF_F000_0001)
      begin errors++; $display("FAIL lw64_data: got %h %h exp 1 fffffffff0000001", wb_valid64, wb_data64); end
  endtask

  task automatic test_flush();
    // Flush during WAIT, then an errored response: nothing reported
    in_valid32 = 1; mem_read = 1; mem_type = 3'b010; alu = 64'h1000; rd = 5'd4; reg_write = 1;
    wb_sel = 2'b01; bus32.dbus_gnt = 1;
    tick();
    bus32.dbus_gnt = 0; flush = 1;
    #1;
    checks++; if (stall32 !== 1'b1 || fsm32 !== 2'd2)
      begin errors++; $display("FAIL fl_wait: got stall %h fsm %h exp 1 2", stall32, fsm32); end
    tick();
    flush = 0; bus32.dbus_rvalid = 1; bus32.dbus_err = 1;
    #1;
    checks++; if (stall32 !== 1'b0) begin errors++; $display("FAIL fl_stall: got %h exp 0", stall32); end
    tick();
    clear_inputs();
    checks++; if (wb_valid32 !== 1'b0 || exc_valid32 !== 1'b0 || fsm32 !== 2'd0)
      begin errors++; $display("FAIL fl_kill: got wb %h exc %h fsm %h exp 0 0 0", wb_valid32, exc_valid32, fsm32); end
    // Flush in IDLE suppresses the request
    in_valid32 = 1; mem_read = 1; mem_type = 3'b010; alu = 64'h1000; flush = 1; bus32.dbus_gnt = 1;
    #1;
    checks++; if (bus32.dbus_req !== 1'b0 || stall32 !== 1'b0)
      begin errors++; $display("FAIL fl_idle: got req %h stall %h exp 0 0", bus32.dbus_req, stall32); end
    tick();
    clear_inputs();
    checks++; if (wb_valid32 !== 1'b0 || fsm32 !== 2'd0)
      begin errors++; $display("FAIL fl_idle_wb: got %h %h exp 0 0", wb_valid32, fsm32); end
    // Flush in REQ keeps the request raised until granted
    in_valid32 = 1; mem_read = 1; mem_type = 3'b000; alu = 64'h1001; reg_write = 1; wb_sel = 2'b01;
    tick();
    flush = 1;
    #1;
    checks++; if (bus32.dbus_req !== 1'b1 || fsm32 !== 2'd1)
      begin errors++; $display("FAIL fl_req_hold: got req %h fsm %h exp 1 1", bus32.dbus_req, fsm32); end
    tick();
    flush = 0; bus32.dbus_gnt = 1;
    tick();
    bus32.dbus_gnt = 0; bus32.dbus_rvalid = 1; bus32.dbus_rdata = 32'h0000_5500;
    tick();
    clear_inputs();
    checks++; if (wb_valid32 !== 1'b0 || exc_valid32 !== 1'b0 || fsm32 !== 2'd0)
      begin errors++; $display("FAIL fl_req_kill: got wb %h exc %h fsm %h exp 0 0 0", wb_valid32, exc_valid32, fsm32); end
    // Stray rvalid in IDLE
    bus32.dbus_rvalid = 1; bus32.dbus_err = 1;
    tick();
    clear_inputs();
    checks++; if (wb_valid32 !== 1'b0 || exc_valid32 !== 1'b0 || fsm32 !== 2'd0)
      begin errors++; $display("FAIL stray_rvalid: got wb %h exc %h fsm %h exp 0 0 0", wb_valid32, exc_valid32, fsm32); end
  endtask

  task automatic test_bus_error();
    in_valid32 = 1; mem_write = 1; mem_type = 3'b010; alu = 64'h5008; sdata = 64'hDEAD_BEEF; bus32.dbus_gnt = 1;
    #1;
    checks++; if (bus32.dbus_strb !== 4'b1111 || bus32.dbus_wdata !== 32'hDEAD_BEEF)
      begin errors++; $display("FAIL sw_lanes: got strb %b wdata %h exp 1111 deadbeef", bus32.dbus_strb, bus32.dbus_wdata); end
    tick();
    bus32.dbus_gnt = 0; bus32.dbus_rvalid = 1; bus32.dbus_err = 1;
    tick();
    clear_inputs();
    checks++; if (exc_valid32 !== 1'b1 || exc_cause32 !== 4'd7 || exc_addr32 !== 32'h5008 || wb_valid32 !== 1'b0)
      begin errors++; $display("FAIL st_fault: got %h %h %h wb %h exp 1 7 5008 0", exc_valid32, exc_cause32, exc_addr32, wb_valid32); end
  endtask

  task automatic test_back_to_back_alu();
    in_valid32 = 1; wb_sel = 2'b10; link = 64'h100; alu = 64'h55; rd = 5'd7; reg_write = 1;
    #1;
    checks++; if (stall32 !== 1'b0 || bus32.dbus_req !== 1'b0)
      begin errors++; $display("FAIL alu_no_bus: got stall %h req %h exp 0 0", stall32, bus32.dbus_req); end
    tick();
    checks++; if (wb_valid32 !== 1'b1 || wb_data32 !== 32'h100 || wb_rd32 !== 5'd7 || wb_reg_write32 !== 1'b1)
      begin errors++; $display("FAIL alu_link: got %h %h %h %h exp 1 100 7 1", wb_valid32, wb_data32, wb_rd32, wb_reg_write32); end
    wb_sel = 2'b00; alu = 64'h1234; rd = 5'd8;
    tick();
    checks++; if (wb_valid32 !== 1'b1 || wb_data32 !== 32'h1234 || wb_rd32 !== 5'd8)
      begin errors++; $display("FAIL alu_b2b: got %h %h %h exp 1 1234 8", wb_valid32, wb_data32, wb_rd32); end
    wb_sel = 2'b11;
    tick();
    clear_inputs();
    checks++; if (wb_valid32 !== 1'b1 || wb_data32 !== 32'h0)
      begin errors++; $display("FAIL alu_zero: got %h %h exp 1 0", wb_valid32, wb_data32); end
  endtask

  task automatic test_reset_in_wait();
    in_valid32 = 1; mem_read = 1; mem_type = 3'b010; alu = 64'h1000; wb_sel = 2'b01; bus32.dbus_gnt = 1;
    tick();
    bus32.dbus_gnt = 0;
    #1;
    checks++; if (fsm32 !== 2'd2) begin errors++; $display("FAIL rw_fsm_pre: got %h exp 2", fsm32); end
    rst = 1;
    #1;
    checks++; if (bus32.dbus_req !== 1'b0 || stall32 !== 1'b0 || fsm32 !== 2'd0)
      begin errors++; $display("FAIL rw_async: got req %h stall %h fsm %h exp 0 0 0", bus32.dbus_req, stall32, fsm32); end
    checks++; if (wb_valid32 !== 1'b0 || wb_data32 !== 32'h0 || exc_valid32 !== 1'b0 || exc_addr32 !== 32'h0)
      begin errors++; $display("FAIL rw_outs: got %h %h %h %h exp 0 0 0 0", wb_valid32, wb_data32, exc_valid32, exc_addr32); end
    clear_inputs();
    tick();
    rst = 0;
    tick();
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    #1;
    test_reset();
    tick();
    tick();
    rst = 0;
    tick();
    test_load_byte();
    test_store_half();
    test_misaligned();
    test_lwu_64();
    test_flush();
    test_bus_error();
    test_back_to_back_alu();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
